// File: rtl/uart_rx_460k.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_460k : 8N1 UART receiver, mid-bit sampling, valid/ready output,  |
// |                framing/overrun/parity error pulses.                      |
// | Optional: define UART_RX_PARITY_EN for an even-parity bit before stop.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_460k #(
  parameter int CLK_DIV  = 108,
  parameter int HALF_DIV = CLK_DIV / 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       parity_err
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            pend_good;
  logic            pend_ferr;
`ifdef UART_RX_PARITY_EN
  logic            par_bad;
  logic            pend_perr;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'd0;
      pend_good   <= 1'b0;
      pend_ferr   <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      pend_perr   <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx_in;
      rx_s        <= rx_meta;
      pend_good   <= 1'b0;
      pend_ferr   <= 1'b0;
      overrun_err <= 1'b0;
      frame_err   <= pend_ferr;
`ifdef UART_RX_PARITY_EN
      pend_perr   <= 1'b0;
      parity_err  <= pend_perr;
`endif

      // Commit stage runs one cycle after the stop-bit sample.
      if (pend_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bad <= rx_s ^ (^shreg);
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            // A good stop returns to idle half a bit early to resync on the next start edge.
            if (rx_s) begin
              state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              pend_good <= !par_bad;
              pend_perr <= par_bad;
`else
              pend_good <= 1'b1;
`endif
            end else begin
              state     <= S_BREAK;
              pend_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_460k.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_460k : randomized frames against an event-level model of      |
// |                   uart_rx_460k. Honours UART_RX_PARITY_EN.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_rx_460k;

  localparam int D = 108;
  localparam int H = 54;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NPAY   = 10;
  localparam int LAT    = 1137;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NPAY   = 9;
  localparam int LAT    = 1029;
`endif
  // Falling edge driven just after posedge 'launch'; first capture at launch+1,
  // stop sample 2+H+NPAY*D later, outputs move one edge after that.
  localparam int COMMIT_OFS = 4 + H + NPAY * D;

  localparam int K_GOOD  = 0;
  localparam int K_FRAME = 1;
  localparam int K_PAR   = 2;

  typedef struct {
    int         at;
    int         kind;
    logic [7:0] b;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  uart_rx_460k #(.CLK_DIV(D), .HALF_DIV(H)) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_err    = 0;
  ev_t  ev_q[$];
  int   ready_mode = 0;
  int   ready_pulse_cyc = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'd0;
  logic       m_fe = 1'b0, m_oe = 1'b0, m_pe = 1'b0;
  logic       pv = 1'b0;
  int         last_rise = 0, last_fall = 0;
  int         cnt_rise = 0, cnt_fe = 0, cnt_oe = 0, cnt_pe = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: apply scheduled frame outcomes at their edge, then compare.
  always @(negedge clk) begin
    ev_t e;
    bit  loaded;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'd0;
      m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
      ev_q.delete();
    end else begin
      m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
      loaded = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].at == cyc) begin
        e = ev_q.pop_front();
        case (e.kind)
          K_GOOD: begin
            if (!m_valid || rx_ready) begin
              m_data  = e.b;
              m_valid = 1'b1;
              loaded  = 1'b1;
            end else begin
              m_oe = 1'b1;
            end
          end
          K_FRAME: m_fe = 1'b1;
          default: m_pe = 1'b1;
        endcase
      end
      if (!loaded && m_valid && rx_ready) m_valid = 1'b0;
    end

    check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
    check("overrun_err", {31'd0, overrun_err}, {31'd0, m_oe});
    check("parity_err", {31'd0, parity_err}, {31'd0, m_pe});

    if (rx_valid && !pv) begin last_rise = cyc; cnt_rise++; end
    if (!rx_valid && pv) last_fall = cyc;
    pv = rx_valid;
    cnt_fe += int'(frame_err);
    cnt_oe += int'(overrun_err);
    cnt_pe += int'(parity_err);

    case (ready_mode)
      0:       rx_ready = 1'b1;
      1:       rx_ready = 1'b0;
      2:       rx_ready = 1'($urandom_range(0, 1));
      default: rx_ready = (cyc + 1 == ready_pulse_cyc);
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip,
                            input int low_hold, output int launch);
    ev_t e;
    e.at   = cyc + COMMIT_OFS;
    e.b    = b;
    e.kind = K_GOOD;
    if (!stop_bit) e.kind = K_FRAME;
    else if (par_flip && PAR_EN) e.kind = K_PAR;
    ev_q.push_back(e);
    launch = cyc;
    rx_in  = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(D);
    end
    if (PAR_EN) begin
      rx_in = (^b) ^ par_flip;
      tick(D);
    end
    rx_in = stop_bit;
    tick(D);
    if (!stop_bit) tick(low_hold);
    rx_in = 1'b1;
  endtask

  task automatic glitch(input int len);
    rx_in = 1'b0;
    tick(len);
    rx_in = 1'b1;
    tick(H + 10);
  endtask

  initial begin
    int l, s0, s1, s2, r;
    rst_n = 1'b0;
    rx_in = 1'b1;
    tick(5);
    rst_n = 1'b1;
    tick(10);

    // Single frame: data, latency, one-cycle valid with ready held high.
    send_frame(8'hA5, 1'b1, 1'b0, 0, l);
    tick(20);
    check("lat_a5", last_rise - (l + 1), LAT);
    check("clr_a5", last_fall - last_rise, 1);
    check("data_a5", {24'd0, rx_data}, 32'hA5);

    // Short low glitch on an idle line.
    s0 = cnt_rise; s1 = cnt_fe + cnt_oe + cnt_pe;
    glitch(30);
    check("glitch_valid", cnt_rise - s0, 0);
    check("glitch_errs", cnt_fe + cnt_oe + cnt_pe - s1, 0);

    // Bad stop bit then long break, followed by a clean frame.
    s0 = cnt_rise; s1 = cnt_fe;
    send_frame(8'h3C, 1'b0, 1'b0, 3000, l);
    tick(20);
    check("brk_fe", cnt_fe - s1, 1);
    check("brk_valid", cnt_rise - s0, 0);
    send_frame(8'h55, 1'b1, 1'b0, 0, l);
    tick(20);
    check("data_55", {24'd0, rx_data}, 32'h55);

    // Overrun: consumer stalled across two frames.
    ready_mode = 1;
    s0 = cnt_oe;
    send_frame(8'h11, 1'b1, 1'b0, 0, l);
    tick(10);
    send_frame(8'h22, 1'b1, 1'b0, 0, l);
    tick(20);
    check("ovr_data", {24'd0, rx_data}, 32'h11);
    check("ovr_pulse", cnt_oe - s0, 1);
    ready_mode = 0;
    tick(3);
    check("ovr_clear", {31'd0, rx_valid}, 32'd0);

    // Ready asserted exactly on the commit edge of a second byte.
    ready_mode = 1;
    send_frame(8'h33, 1'b1, 1'b0, 0, l);
    tick(10);
    s0 = cnt_oe;
    ready_pulse_cyc = cyc + COMMIT_OFS;
    ready_mode = 3;
    send_frame(8'h44, 1'b1, 1'b0, 0, l);
    tick(10);
    check("exact_data", {24'd0, rx_data}, 32'h44);
    check("exact_valid", {31'd0, rx_valid}, 32'd1);
    check("exact_novr", cnt_oe - s0, 0);
    ready_mode = 0;
    tick(3);

    if (PAR_EN) begin
      s0 = cnt_rise; s1 = cnt_pe;
      send_frame(8'h07, 1'b1, 1'b1, 0, l);
      tick(20);
      check("par_pulse", cnt_pe - s1, 1);
      check("par_novalid", cnt_rise - s0, 0);
      send_frame(8'h07, 1'b1, 1'b0, 0, l);
      tick(20);
      check("par_data", {24'd0, rx_data}, 32'h07);
    end

    // Reset in the middle of the data bits while a byte is held.
    ready_mode = 1;
    send_frame(8'h5A, 1'b1, 1'b0, 0, l);
    tick(5);
    check("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
    rx_in = 1'b0;
    tick(H + 3 * D);
    rst_n = 1'b0;
    rx_in = 1'b1;
    tick(1);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_errs", {29'd0, frame_err, overrun_err, parity_err}, 32'd0);
    tick(4);
    rst_n = 1'b1;
    ready_mode = 0;
    tick(2 * D);

    // Randomized traffic with a random consumer.
    ready_mode = 2;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch($urandom_range(1, 40));
      end else if (r == 1) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, $urandom_range(0, 200), l);
      end else if (r == 2) begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 0, l);
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 0, l);
      end
      tick(4 + $urandom_range(0, 30));
    end
    ready_mode = 0;
    tick(3 * D);
    check("queue_drained", ev_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
